alu_request_arbiter: RTL and testbench
======================================

Name: alu_request_arbiter

Overview:
- Shares one `arithmetic_logic_unit` instance between NUM_REQUESTERS clients, e.g. the execute stage and the address/branch helper path.
- Each client has a valid/ready request channel carrying operands plus a decoded instruction, and a valid/ready response channel carrying the result.
- The arbiter grants round-robin, registers the ALU result in a one-entry output buffer tagged with its owner, and holds that result until the owner accepts it.

Parameters:
- NUM_REQUESTERS, 2, number of clients sharing the ALU; legal range 2..4.
- ID_WIDTH, $clog2(NUM_REQUESTERS), width of the owner/grant index.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  [NUM_REQUESTERS]  client i presents an operation.
- req_ready  output  [NUM_REQUESTERS]  client i's operation is accepted this cycle.
- req_input1  input  [NUM_REQUESTERS][REGISTER_WIDTH]  operand 1 per client.
- req_input2  input  [NUM_REQUESTERS][REGISTER_WIDTH]  operand 2 per client.
- req_instruction  input  [NUM_REQUESTERS] instruction_t  decoded instruction per client.
- rsp_valid  output  [NUM_REQUESTERS]  result available for client i.
- rsp_ready  input  [NUM_REQUESTERS]  client i consumes its result.
- rsp_result  output  REGISTER_WIDTH  registered ALU result, shared by all clients; meaningful only where rsp_valid is high.
- busy  output  1  output buffer occupied (out_valid).

Behaviour:
- State: out_valid (1b), out_owner (ID_WIDTH), out_result (REGISTER_WIDTH), last_grant (ID_WIDTH).
- Reset values: out_valid=0, out_owner=0, out_result=0, last_grant=NUM_REQUESTERS-1, so client 0 has first priority.
- While reset is high: req_ready=0 and rsp_valid=0; no request is accepted.
- Two-state view:
  - EMPTY (out_valid=0).
  - HOLD (out_valid=1).
- can_issue = !out_valid || rsp_ready[out_owner].
- Grant logic is combinational:
  - If can_issue, search req_valid starting at last_grant+1 modulo NUM_REQUESTERS, wrapping.
  - The first valid client found is the grant; at most one req_ready bit is high.
  - req_ready[g] = can_issue && req_valid[g] && !reset. req_ready depends on req_valid; this is documented and accepted.
- On a grant (handshake req_valid[g] && req_ready[g]) at cycle N:
  - ALU inputs are muxed from client g.
  - At edge N+1: out_result takes the ALU result, out_owner=g, out_valid=1, last_grant=g.
  - Latency 1 cycle: rsp_valid[g] is high in cycle N+1.
- Drain: rsp_valid[i] = out_valid && out_owner==i. When rsp_ready[out_owner] is high and there is no new grant, out_valid clears next edge.
- Simultaneous drain and grant: the buffer is overwritten with the new result (out_valid stays 1). This gives full throughput of 1 operation per cycle under no backpressure.
- Backpressure: while HOLD and rsp_ready[out_owner]=0:
  - out_result, out_owner and out_valid are stable.
  - All req_ready are 0.
- rsp_ready of non-owning clients is ignored.
- Fairness: any client with continuously asserted req_valid is granted within NUM_REQUESTERS accepted grants.
- last_grant updates only on an actual grant. An idle cycle does not rotate priority.
- Request stability: clients hold operands and instruction stable while req_valid && !req_ready. The arbiter samples only on handshake.
- Reset mid-operation: a held result is discarded (out_valid=0) with no response delivered. In-flight requests must be reissued by the clients.
- ALU arithmetic: width REGISTER_WIDTH. The arbiter adds no transformation; unsupported opcodes yield result 0, which is still delivered with rsp_valid.

Decomposition:
- Shared package `common` (existing) supplies REGISTER_WIDTH, instruction_t and the opcode/funct3 constants. Add to it:
  - ALU_MAX_REQUESTERS = 4.
  - alu_req_t, a struct of {input1, input2, instruction}, so request ports may be packed as alu_req_t [NUM_REQUESTERS].
- Sub-module: one instance of `arithmetic_logic_unit`.
- The round-robin pick may be a local function, or a small sub-module `round_robin_picker` (req vector, last_grant → grant index, grant_valid), reusable elsewhere.

Test Plan:
- Reset, then client 0 issues OPCODE_ARITHMETIC/ADD_OR_SUB with 5, 7 and rsp_ready[0]=1 → req_ready[0]=1 in cycle N; rsp_valid[0]=1 with rsp_result=12 in N+1; busy=0 in N+2.
- Both clients valid from the first cycle after reset (c0: ADD 1+2, c1: XOR 0xF0^0xFF), rsp_ready all high → c0 granted first (result 3), c1 next cycle (result 0x0F); c0 re-requesting is not regranted before c1.
- Backpressure: c1 result 0x0F held with rsp_ready[1]=0 for 5 cycles while c0 is valid → rsp_result stable at 0x0F, req_ready all 0; on rsp_ready[1]=1, c0 is granted in that same cycle.
- Streaming: c0 issues 8 back-to-back ORI ops (i | 0x100) with rsp_ready held high → 8 results on 8 consecutive cycles, no bubbles, values 0x100..0x107.
- Reset asserted while busy=1 with rsp_ready low → next cycle rsp_valid=0 and busy=0; the first post-reset grant goes to client 0 even if client 1 was last granted.
- Unsupported opcode from c1 → rsp_valid[1]=1 with rsp_result=0 after 1 cycle; rsp_ready[0] toggling while out_owner=1 has no effect.

Source files
------------

// File: rtl/common.sv
// Shared core definitions: register width, decoded instruction format and opcode constants,
// plus the request record and state encoding used by the shared-ALU arbiter.
package common;

    localparam int REGISTER_WIDTH = 32;

    localparam logic [6:0] OPCODE_ARITHMETIC     = 7'b0110011;
    localparam logic [6:0] OPCODE_ARITHMETIC_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI            = 7'b0110111;

    localparam logic [2:0] FUNCT3_ADD_OR_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL        = 3'b001;
    localparam logic [2:0] FUNCT3_SLT        = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU       = 3'b011;
    localparam logic [2:0] FUNCT3_XOR        = 3'b100;
    localparam logic [2:0] FUNCT3_SRL_OR_SRA = 3'b101;
    localparam logic [2:0] FUNCT3_OR         = 3'b110;
    localparam logic [2:0] FUNCT3_AND        = 3'b111;

    // alternate selects SUB (register form only) and SRA/SRAI
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       alternate;
    } instruction_t;

    localparam int ALU_MAX_REQUESTERS = 4;

    typedef struct packed {
        logic [REGISTER_WIDTH-1:0] input1;
        logic [REGISTER_WIDTH-1:0] input2;
        instruction_t              instruction;
    } alu_req_t;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_HOLD  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arithmetic_logic_unit.sv
// Combinational integer ALU for register and immediate arithmetic forms plus LUI.
// Unsupported opcodes produce zero.
module arithmetic_logic_unit
    import common::*;
(
    input  logic [REGISTER_WIDTH-1:0] input1,
    input  logic [REGISTER_WIDTH-1:0] input2,
    input  instruction_t              instruction,
    output logic [REGISTER_WIDTH-1:0] result
);

    localparam int SHAMT_WIDTH = $clog2(REGISTER_WIDTH);

    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   is_register_form;

    assign shamt            = input2[SHAMT_WIDTH-1:0];
    assign is_register_form = (instruction.opcode == OPCODE_ARITHMETIC);

    always_comb begin
        result = '0;
        if (instruction.opcode == OPCODE_ARITHMETIC || instruction.opcode == OPCODE_ARITHMETIC_IMM) begin
            case (instruction.funct3)
                FUNCT3_ADD_OR_SUB: result = (is_register_form && instruction.alternate) ?
                                            input1 - input2 : input1 + input2;
                FUNCT3_SLL:        result = input1 << shamt;
                FUNCT3_SLT:        result = {{(REGISTER_WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
                FUNCT3_SLTU:       result = {{(REGISTER_WIDTH-1){1'b0}}, (input1 < input2)};
                FUNCT3_XOR:        result = input1 ^ input2;
                FUNCT3_SRL_OR_SRA: result = instruction.alternate ?
                                            $unsigned($signed(input1) >>> shamt) : input1 >> shamt;
                FUNCT3_OR:         result = input1 | input2;
                FUNCT3_AND:        result = input1 & input2;
                default:           result = '0;
            endcase
        end else if (instruction.opcode == OPCODE_LUI) begin
            result = input2;
        end
    end

endmodule

// File: rtl/round_robin_picker.sv
// Round-robin selector: the first asserted request strictly after last_grant, wrapping.
module round_robin_picker #(
    parameter int NUM_REQUESTERS = 2,
    parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] req,
    input  logic [ID_WIDTH-1:0]       last_grant,
    output logic [ID_WIDTH-1:0]       grant,
    output logic                      grant_valid
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester overwrites the others.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int off = NUM_REQUESTERS; off >= 1; off--) begin
            idx = (int'(last_grant) + off) % NUM_REQUESTERS;
            if (req[idx]) begin
                grant       = ID_WIDTH'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_request_arbiter.sv
// Shares one ALU among several valid/ready clients with round-robin grant and a one-entry,
// owner-tagged result buffer held until the owner accepts it.
module alu_request_arbiter
    import common::*;
#(
    parameter int NUM_REQUESTERS = 2,
    parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [NUM_REQUESTERS-1:0]                      req_valid,
    output logic [NUM_REQUESTERS-1:0]                      req_ready,
    input  logic [NUM_REQUESTERS-1:0][REGISTER_WIDTH-1:0]  req_input1,
    input  logic [NUM_REQUESTERS-1:0][REGISTER_WIDTH-1:0]  req_input2,
    input  instruction_t [NUM_REQUESTERS-1:0]              req_instruction,
    output logic [NUM_REQUESTERS-1:0]                      rsp_valid,
    input  logic [NUM_REQUESTERS-1:0]                      rsp_ready,
    output logic [REGISTER_WIDTH-1:0]                      rsp_result,
    output logic                                           busy
);

    // Handshakes: a transfer happens on a channel only in a cycle where both valid and ready
    // are high; clients keep their request payload stable while valid is high and ready is low.

    arb_state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]       out_owner;
    logic [REGISTER_WIDTH-1:0] out_result;
    logic [ID_WIDTH-1:0]       last_grant;

    logic                      out_valid;
    logic                      can_issue;
    logic                      grant_fire;
    logic                      drain;
    logic [ID_WIDTH-1:0]       grant;
    logic                      grant_valid;
    alu_req_t                  alu_req;
    logic [REGISTER_WIDTH-1:0] alu_result;

    assign out_valid  = (state_q == ARB_HOLD);
    assign drain      = out_valid && rsp_ready[out_owner];
    // The buffer can take a new result when empty or when its owner drains it this cycle.
    assign can_issue  = !out_valid || rsp_ready[out_owner];
    assign grant_fire = can_issue && grant_valid && !reset;

    round_robin_picker #(
        .NUM_REQUESTERS (NUM_REQUESTERS),
        .ID_WIDTH       (ID_WIDTH)
    ) u_picker (
        .req         (req_valid),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        alu_req.input1      = req_input1[grant];
        alu_req.input2      = req_input2[grant];
        alu_req.instruction = req_instruction[grant];
    end

    arithmetic_logic_unit u_alu (
        .input1      (alu_req.input1),
        .input2      (alu_req.input2),
        .instruction (alu_req.instruction),
        .result      (alu_result)
    );

    always_comb begin
        req_ready = '0;
        if (grant_fire) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            rsp_valid[i] = out_valid && !reset && (out_owner == ID_WIDTH'(i));
        end
    end

    assign rsp_result = out_result;
    assign busy       = out_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_EMPTY: if (grant_fire) state_d = ARB_HOLD;
            ARB_HOLD: begin
                if (grant_fire) begin
                    state_d = ARB_HOLD;
                end else if (drain) begin
                    state_d = ARB_EMPTY;
                end
            end
            default: state_d = ARB_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority only rotates on an actual grant, so idle cycles keep the current order.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_owner  <= '0;
            out_result <= '0;
            last_grant <= ID_WIDTH'(NUM_REQUESTERS - 1);
        end else if (grant_fire) begin
            out_owner  <= grant;
            out_result <= alu_result;
            last_grant <= grant;
        end
    end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Bench for alu_request_arbiter: directed sequences, a streamed vector table and a
// result scoreboard fed from accepted requests.
module tb_alu_request_arbiter;
    import common::*;

    localparam int N     = 2;
    localparam int IDW   = 1;
    localparam int W     = REGISTER_WIDTH;
    localparam int EXP_W = IDW + W;
    localparam int NV    = 18;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N-1:0]           req_valid;
    logic [N-1:0]           req_ready;
    logic [N-1:0][W-1:0]    req_input1;
    logic [N-1:0][W-1:0]    req_input2;
    instruction_t [N-1:0]   req_instruction;
    logic [N-1:0]           rsp_valid;
    logic [N-1:0]           rsp_ready;
    logic [W-1:0]           rsp_result;
    logic                   busy;

    int total = 0;
    int bad   = 0;
    logic [EXP_W-1:0] exp_q[$];

    typedef struct {
        instruction_t ins;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl[NV];

    always #5 clk = ~clk;

    alu_request_arbiter #(.NUM_REQUESTERS(N), .ID_WIDTH(IDW)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_input1      (req_input1),
        .req_input2      (req_input2),
        .req_instruction (req_instruction),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_result      (rsp_result),
        .busy            (busy)
    );

    function automatic instruction_t mk(input logic [6:0] op, input logic [2:0] f3, input logic alt);
        instruction_t ins;
        ins.opcode    = op;
        ins.funct3    = f3;
        ins.alternate = alt;
        return ins;
    endfunction

    function automatic logic [W-1:0] model(input instruction_t ins, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        if (ins.opcode == OPCODE_LUI) return b;
        if (ins.opcode != OPCODE_ARITHMETIC && ins.opcode != OPCODE_ARITHMETIC_IMM) return '0;
        case (ins.funct3)
            FUNCT3_ADD_OR_SUB: return (ins.opcode == OPCODE_ARITHMETIC && ins.alternate) ? a - b : a + b;
            FUNCT3_SLL:        return a << sh;
            FUNCT3_SLT:        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            FUNCT3_SLTU:       return (a < b) ? 32'd1 : 32'd0;
            FUNCT3_XOR:        return a ^ b;
            FUNCT3_SRL_OR_SRA: return ins.alternate ? $unsigned($signed(a) >>> sh) : a >> sh;
            FUNCT3_OR:         return a | b;
            default:           return a & b;
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Let combinational outputs settle, score response/request handshakes of this cycle.
    task automatic settle();
        logic [EXP_W-1:0] e;
        #2;
        for (int i = 0; i < N; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: client %0d result 0x%0h with nothing expected", i, rsp_result);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_owner", W'(i), W'(e[EXP_W-1 -: IDW]));
                    check("sb_result", rsp_result, e[W-1:0]);
                end
            end
        end
        check("req_ready_onehot0", W'($countones(req_ready) <= 1), 32'd1);
        check("rsp_valid_onehot0", W'($countones(rsp_valid) <= 1), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                exp_q.push_back({IDW'(i), model(req_instruction[i], req_input1[i], req_input2[i])});
            end
        end
    endtask

    task automatic advance();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input instruction_t ins, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]       = 1'b1;
        req_instruction[i] = ins;
        req_input1[i]      = a;
        req_input2[i]      = b;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        exp_q.delete();
        settle();
        advance();
        reset = 1'b0;
    endtask

    instruction_t i_add, i_sub, i_addi_alt, i_xor, i_ori, i_and, i_sll, i_srai, i_srli, i_slt, i_sltu, i_lui, i_or, i_bad;

    initial begin
        i_add      = mk(OPCODE_ARITHMETIC,     FUNCT3_ADD_OR_SUB, 1'b0);
        i_sub      = mk(OPCODE_ARITHMETIC,     FUNCT3_ADD_OR_SUB, 1'b1);
        i_addi_alt = mk(OPCODE_ARITHMETIC_IMM, FUNCT3_ADD_OR_SUB, 1'b1);
        i_xor      = mk(OPCODE_ARITHMETIC,     FUNCT3_XOR,        1'b0);
        i_ori      = mk(OPCODE_ARITHMETIC_IMM, FUNCT3_OR,         1'b0);
        i_and      = mk(OPCODE_ARITHMETIC,     FUNCT3_AND,        1'b0);
        i_sll      = mk(OPCODE_ARITHMETIC,     FUNCT3_SLL,        1'b0);
        i_srai     = mk(OPCODE_ARITHMETIC_IMM, FUNCT3_SRL_OR_SRA, 1'b1);
        i_srli     = mk(OPCODE_ARITHMETIC_IMM, FUNCT3_SRL_OR_SRA, 1'b0);
        i_slt      = mk(OPCODE_ARITHMETIC,     FUNCT3_SLT,        1'b0);
        i_sltu     = mk(OPCODE_ARITHMETIC,     FUNCT3_SLTU,       1'b0);
        i_lui      = mk(OPCODE_LUI,            3'b000,            1'b0);
        i_or       = mk(OPCODE_ARITHMETIC,     FUNCT3_OR,         1'b0);
        i_bad      = mk(7'h7F,                 3'b000,            1'b0);

        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{i_ori, W'(i), 32'h100, 32'h100 + W'(i)};
        end
        tbl[8]  = '{i_sub,      32'd10,         32'd3,          32'd7};
        tbl[9]  = '{i_addi_alt, 32'd5,          32'd3,          32'd8};
        tbl[10] = '{i_and,      32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0};
        tbl[11] = '{i_sll,      32'd1,          32'h24,         32'h10};
        tbl[12] = '{i_srai,     32'h8000_0000,  32'd4,          32'hF800_0000};
        tbl[13] = '{i_srli,     32'h8000_0000,  32'd4,          32'h0800_0000};
        tbl[14] = '{i_slt,      32'hFFFF_FFFF,  32'd1,          32'd1};
        tbl[15] = '{i_sltu,     32'hFFFF_FFFF,  32'd1,          32'd0};
        tbl[16] = '{i_lui,      32'h0000_DEAD,  32'h1234_5000,  32'h1234_5000};
        tbl[17] = '{i_or,       32'h0000_00A0,  32'h0000_0005,  32'h0000_00A5};

        reset           = 1'b1;
        req_valid       = '0;
        rsp_ready       = '0;
        req_input1      = '0;
        req_input2      = '0;
        req_instruction = '0;
        advance();
        advance();

        // Requests are refused while reset is held.
        set_req(0, i_add, 32'd5, 32'd7);
        settle();
        check("rst_req_ready", W'(req_ready), 32'd0);
        check("rst_rsp_valid", W'(rsp_valid), 32'd0);
        advance();
        reset     = 1'b0;
        req_valid = '0;
        settle();
        check("rst_busy", W'(busy), 32'd0);
        check("rst_rsp_valid_after", W'(rsp_valid), 32'd0);
        advance();

        // Single ADD with one-cycle latency.
        set_req(0, i_add, 32'd5, 32'd7);
        rsp_ready = 2'b11;
        settle();
        check("t1_req_ready", W'(req_ready), 32'd1);
        advance();
        req_valid = '0;
        settle();
        check("t1_rsp_valid", W'(rsp_valid), 32'd1);
        check("t1_result", rsp_result, 32'd12);
        advance();
        settle();
        check("t1_busy_after", W'(busy), 32'd0);
        advance();

        // Round-robin between two clients, then backpressure on client 1.
        do_reset();
        set_req(0, i_add, 32'd1, 32'd2);
        set_req(1, i_xor, 32'hF0, 32'hFF);
        rsp_ready = 2'b11;
        settle();
        check("rr_first_grant", W'(req_ready), 32'b01);
        advance();
        settle();
        check("rr_second_grant", W'(req_ready), 32'b10);
        check("rr_c0_rsp_valid", W'(rsp_valid), 32'b01);
        check("rr_c0_result", rsp_result, 32'd3);
        advance();
        req_valid[1] = 1'b0;
        rsp_ready    = 2'b01;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("bp_rsp_valid", W'(rsp_valid), 32'b10);
            check("bp_result", rsp_result, 32'h0F);
            check("bp_req_ready", W'(req_ready), 32'd0);
            check("bp_busy", W'(busy), 32'd1);
            advance();
        end
        rsp_ready = 2'b11;
        settle();
        check("bp_release_grant", W'(req_ready), 32'b01);
        advance();
        req_valid = '0;
        settle();
        check("bp_next_rsp_valid", W'(rsp_valid), 32'b01);
        check("bp_next_result", rsp_result, 32'd3);
        advance();
        settle();
        advance();

        // Back-to-back vector stream from client 0: one result per cycle, no bubbles.
        rsp_ready = 2'b11;
        for (int k = 0; k <= NV; k++) begin
            if (k < NV) begin
                set_req(0, tbl[k].ins, tbl[k].a, tbl[k].b);
            end else begin
                req_valid = '0;
            end
            settle();
            if (k < NV) check("vec_req_ready", W'(req_ready), 32'b01);
            if (k > 0) begin
                check("vec_rsp_valid", W'(rsp_valid), 32'b01);
                check("vec_result", rsp_result, tbl[k-1].exp);
            end
            advance();
        end
        settle();
        check("vec_busy_after", W'(busy), 32'd0);
        advance();

        // Reset while a result is held discards it and restores client 0 priority.
        set_req(1, i_add, 32'd2, 32'd2);
        rsp_ready = 2'b00;
        settle();
        check("rm_grant_c1", W'(req_ready), 32'b10);
        advance();
        req_valid = '0;
        settle();
        check("rm_busy_held", W'(busy), 32'd1);
        check("rm_rsp_valid_held", W'(rsp_valid), 32'b10);
        advance();
        reset = 1'b1;
        exp_q.delete();
        set_req(0, i_add, 32'd6, 32'd1);
        set_req(1, i_add, 32'd2, 32'd2);
        settle();
        check("rm_rst_req_ready", W'(req_ready), 32'd0);
        check("rm_rst_rsp_valid", W'(rsp_valid), 32'd0);
        advance();
        reset     = 1'b0;
        rsp_ready = 2'b11;
        settle();
        check("rm_busy_after", W'(busy), 32'd0);
        check("rm_rsp_valid_after", W'(rsp_valid), 32'd0);
        check("rm_first_grant", W'(req_ready), 32'b01);
        advance();
        req_valid[0] = 1'b0;
        settle();
        check("rm_c0_result", rsp_result, 32'd7);
        check("rm_c1_grant", W'(req_ready), 32'b10);
        advance();
        req_valid = '0;
        settle();
        check("rm_c1_result", rsp_result, 32'd4);
        advance();
        settle();
        advance();

        // Unsupported opcode still responds with zero; non-owner rsp_ready is ignored.
        set_req(1, i_bad, 32'h0000_DEAD, 32'h0000_BEEF);
        rsp_ready = 2'b00;
        settle();
        check("un_grant", W'(req_ready), 32'b10);
        advance();
        req_valid[1] = 1'b0;
        set_req(0, i_add, 32'd9, 32'd9);
        for (int k = 0; k < 4; k++) begin
            rsp_ready = {1'b0, k[0]};
            settle();
            check("un_rsp_valid", W'(rsp_valid), 32'b10);
            check("un_result", rsp_result, 32'd0);
            check("un_req_ready", W'(req_ready), 32'd0);
            advance();
        end
        rsp_ready = 2'b11;
        settle();
        check("un_release_grant", W'(req_ready), 32'b01);
        advance();
        req_valid = '0;
        settle();
        check("un_c0_result", rsp_result, 32'd18);
        advance();
        settle();
        check("final_busy", W'(busy), 32'd0);
        check("sb_drained", W'(exp_q.size()), 32'd0);
        advance();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
